// File: rtl/pe_log_pkg.sv
// Shared definitions for the log-domain PE datapath.
//   INT_W / FRAC_W : integer (shift) and fraction widths of a log operand (Q5.11)
//   CORR_W         : width of one Mitchell correction entry (units of 2^-FRAC_W)
//   CORR_TABLE     : 16-entry piecewise correction, indexed by the top 4 fraction bits
//   log_op_t       : one log-domain operand {int_part, frac, zero, sign}
package pe_log_pkg;

  localparam int INT_W  = 5;
  localparam int FRAC_W = 11;
  localparam int CORR_W = 8;
  localparam int IDX_W  = 4;
  localparam int LOG_W  = INT_W + FRAC_W;

  // Mantissa 1+f is FRAC_W+1 bits; shifting it left by up to 2^INT_W-1 and
  // dropping the FRAC_W fraction bits leaves LIN_W integer bits.
  localparam int SHIFT_W = FRAC_W + 1 + (1 << INT_W) - 1;
  localparam int LIN_W   = SHIFT_W - FRAC_W;

  // Index 0 is the leftmost entry.
  localparam logic [0:15][CORR_W-1:0] CORR_TABLE = {
    8'd19,  8'd54,  8'd86,  8'd113, 8'd135, 8'd153, 8'd166, 8'd174,
    8'd176, 8'd173, 8'd164, 8'd149, 8'd128, 8'd100, 8'd66,  8'd24
  };

  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac;
    logic              zero;
    logic              sign;
  } log_op_t;

  // Correction segment selected by the most significant fraction bits.
  function automatic logic [IDX_W-1:0] corr_idx(input logic [FRAC_W-1:0] frac);
    return frac[FRAC_W-1 -: IDX_W];
  endfunction

endpackage

// File: rtl/exp_offset_conv_if.sv
// Handshake bundle of the antilog converter.
//   in_valid/in_ready  : input transfer, in_log = {int[4:0], frac[10:0]}, in_zero, in_sign
//   out_valid/out_ready: output transfer, out_lin (OUT_W bits), out_sign
// master = producer/consumer environment, slave = the converter.
interface exp_offset_conv_if #(
  parameter int OUT_W = 32
) ();
  import pe_log_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [LOG_W-1:0] in_log;
  logic             in_zero;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_lin;
  logic             out_sign;

  modport master (
    output in_valid, in_log, in_zero, in_sign, out_ready,
    input  in_ready, out_valid, out_lin, out_sign
  );

  modport slave (
    input  in_valid, in_log, in_zero, in_sign, out_ready,
    output in_ready, out_valid, out_lin, out_sign
  );

endinterface

// File: rtl/lut_exp_offset.sv
// Registered Mitchell correction lookup.
//   clk, rst_n : clock, asynchronous active-low reset (corr clears to 0)
//   en         : load enable, driven by the stage-1 advance of the converter
//   idx        : segment index (top 4 fraction bits of the incoming operand)
//   corr       : correction for the operand now held in stage 1
module lut_exp_offset (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] idx,
  output logic [7:0] corr
);
  import pe_log_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr <= '0;
    end else if (en) begin
      corr <= CORR_TABLE[idx];
    end
  end

endmodule

// File: rtl/exp_offset_conv.sv
// Log-to-linear (antilog) converter, 3-stage valid/ready pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : exp_offset_conv_if slave port (in_* handshake in, out_* handshake out)
// Stage 1 registers the operand and looks up the correction, stage 2 forms the
// mantissa 1+f-corr, stage 3 shifts it to a linear magnitude (truncated,
// saturated to OUT_W bits, forced to 0 for a zero operand).
module exp_offset_conv #(
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exp_offset_conv_if.slave      bus
);
  import pe_log_pkg::*;

  // Stage registers
  logic              v1, v2, v3;
  log_op_t           s1;
  logic [CORR_W-1:0] corr1;
  logic [INT_W-1:0]  sh2;
  logic [FRAC_W:0]   m2;
  logic              zero2, sign2;
  logic [OUT_W-1:0]  lin3;
  logic              sign3;

  // Stall chain: a stage may take new data when it is empty or its contents
  // move on this cycle. This is combinational all the way from out_ready.
  logic adv1, adv2, adv3;
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.out_lin   = lin3;
  assign bus.out_sign  = sign3;

  // The correction register advances with stage 1, so corr1 always belongs to s1.
  lut_exp_offset u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv1),
    .idx   (corr_idx(bus.in_log[FRAC_W-1:0])),
    .corr  (corr1)
  );

  // Stage 2 datapath: 2048 + frac is just {1, frac}; the result stays within
  // 2029..4071, so FRAC_W+1 bits are enough with no wrap.
  logic [FRAC_W:0] m_next;
  assign m_next = {1'b1, s1.frac} - {{(FRAC_W + 1 - CORR_W){1'b0}}, corr1};

  // Stage 3 datapath: full-width shift, then drop the fraction bits (truncate).
  logic [SHIFT_W-1:0] shifted;
  logic [LIN_W-1:0]   lin_full;
  logic [OUT_W-1:0]   lin_sat;
  logic [OUT_W-1:0]   lin_next;

  assign shifted  = {{(SHIFT_W - FRAC_W - 1){1'b0}}, m2} << sh2;
  assign lin_full = LIN_W'(shifted >> FRAC_W);

  if (OUT_W < LIN_W) begin : g_sat
    assign lin_sat = (|lin_full[LIN_W-1:OUT_W]) ? '1 : lin_full[OUT_W-1:0];
  end else begin : g_nosat
    assign lin_sat = OUT_W'(lin_full);
  end

  assign lin_next = zero2 ? '0 : lin_sat;

  // NOTE: every register here is a flop (not a memory array), so all of them
  // take the async reset; in-flight data is discarded, and out_lin reads 0 at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      // NOTE: non-blocking assignments keep every stage reading the value its
      // neighbour held before this edge, which is what makes the pipe shift.
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1.int_part <= bus.in_log[LOG_W-1:FRAC_W];
        s1.frac     <= bus.in_log[FRAC_W-1:0];
        s1.zero     <= bus.in_zero;
        s1.sign     <= bus.in_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sh2   <= '0;
      m2    <= '0;
      zero2 <= 1'b0;
      sign2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        sh2   <= s1.int_part;
        m2    <= m_next;
        zero2 <= s1.zero;
        sign2 <= s1.sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      lin3  <= '0;
      sign3 <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        lin3  <= lin_next;
        sign3 <= sign2;
      end
    end
  end

endmodule

// File: tb/tb_exp_offset_conv.sv
// Self-checking bench for exp_offset_conv: a 32-bit and a 16-bit output
// instance share one stimulus stream; a queue-based scoreboard holds the
// expected results computed from plain arithmetic.
module tb_exp_offset_conv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_offset_conv_if #(.OUT_W(32)) bus ();
  exp_offset_conv_if #(.OUT_W(16)) bus16 ();

  exp_offset_conv #(.OUT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_offset_conv #(.OUT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  assign bus16.in_valid  = bus.in_valid;
  assign bus16.in_log    = bus.in_log;
  assign bus16.in_zero   = bus.in_zero;
  assign bus16.in_sign   = bus.in_sign;
  assign bus16.out_ready = bus.out_ready;

  typedef struct {
    logic [31:0] lin32;
    logic [15:0] lin16;
    logic        sign;
    int          issue;
  } exp_t;

  typedef struct {
    int          ip;
    int          fr;
    bit          z;
    bit          s;
    logic [31:0] e32;
    logic [15:0] e16;
  } vec_t;

  int corr_tab [16] = '{19, 54, 86, 113, 135, 153, 166, 174,
                        176, 173, 164, 149, 128, 100, 66, 24};

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        q[$];
  exp_t        next_exp;
  bit          check_lat = 0;
  bit          chk_ready = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_lin;
  logic        prev_sign;
  vec_t        vecs [9];

  // Antilog from the arithmetic definition: 2^int * (1 + f - corr), truncated.
  function automatic longint model_lin(int ip, int fr, bit z, int ow);
    longint m;
    longint lin;
    if (z) return 0;
    m   = 2048 + fr - corr_tab[fr / 128];
    lin = (m * (longint'(1) << ip)) / 2048;
    if (lin >= (longint'(1) << ow)) lin = (longint'(1) << ow) - 1;
    return lin;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_op(int ip, int fr, bit z, bit s);
    logic [4:0]  ib;
    logic [10:0] fb;
    ib = ip[4:0];
    fb = fr[10:0];
    bus.in_log     = {ib, fb};
    bus.in_zero    = z;
    bus.in_sign    = s;
    next_exp.lin32 = 32'(model_lin(ip, fr, z, 32));
    next_exp.lin16 = 16'(model_lin(ip, fr, z, 16));
    next_exp.sign  = s;
  endtask

  task automatic rand_op();
    set_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 2047)),
           ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)));
  endtask

  // Called at a negedge with inputs applied; samples, scores, advances one cycle.
  task automatic cycle();
    exp_t e;
    #1;
    if (prev_stall) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_lin", 64'(bus.out_lin), 64'(prev_lin));
      check("hold_sign", 64'(bus.out_sign), 64'(prev_sign));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_lin   = bus.out_lin;
    prev_sign  = bus.out_sign;
    if (chk_ready) check("in_ready_stream", 64'(bus.in_ready), 64'd1);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_out: got lin 0x%0h, expected no output (cycle %0d)", bus.out_lin, cyc);
      end else begin
        e = q.pop_front();
        check("out_lin32", 64'(bus.out_lin), 64'(e.lin32));
        check("out_lin16", 64'(bus16.out_lin), 64'(e.lin16));
        check("out_sign", 64'(bus.out_sign), 64'(e.sign));
        if (check_lat) check("latency", 64'(cyc - e.issue), 64'd3);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e = next_exp;
      e.issue = cyc;
      q.push_back(e);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n_acc;

    vecs[0] = '{ip: 3,  fr: 'h400, z: 0, s: 0, e32: 32'd11,         e16: 16'd11};
    vecs[1] = '{ip: 11, fr: 0,     z: 0, s: 0, e32: 32'd2029,       e16: 16'd2029};
    vecs[2] = '{ip: 12, fr: 0,     z: 0, s: 1, e32: 32'd4058,       e16: 16'd4058};
    vecs[3] = '{ip: 31, fr: 'h7FF, z: 0, s: 0, e32: 32'hFE700000,   e16: 16'hFFFF};
    vecs[4] = '{ip: 20, fr: 'h3FF, z: 1, s: 1, e32: 32'd0,          e16: 16'd0};
    vecs[5] = '{ip: 0,  fr: 0,     z: 0, s: 0, e32: 32'd0,          e16: 16'd0};
    vecs[6] = '{ip: 16, fr: 'h7FF, z: 0, s: 1, e32: 32'd130272,     e16: 16'hFFFF};
    vecs[7] = '{ip: 15, fr: 'h080, z: 0, s: 0, e32: 32'd33952,      e16: 16'd33952};
    vecs[8] = '{ip: 31, fr: 0,     z: 1, s: 0, e32: 32'd0,          e16: 16'd0};

    bus.in_valid  = 1'b0;
    bus.in_log    = '0;
    bus.in_zero   = 1'b0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;
    next_exp      = '{lin32: '0, lin16: '0, sign: 1'b0, issue: 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_lin", 64'(bus.out_lin), 64'd0);
    check("rst_out_sign", 64'(bus.out_sign), 64'd0);
    check("rst_out_lin16", 64'(bus16.out_lin), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed table, one operand at a time, latency checked
    bus.out_ready = 1'b1;
    check_lat = 1;
    for (int i = 0; i < 9; i++) begin
      set_op(vecs[i].ip, vecs[i].fr, vecs[i].z, vecs[i].s);
      next_exp.lin32 = vecs[i].e32;
      next_exp.lin16 = vecs[i].e16;
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      drain();
    end

    // Back-to-back stream of 8; latency 3 on each implies consecutive outputs
    chk_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rand_op();
      bus.in_valid = 1'b1;
      cycle();
    end
    chk_ready = 0;
    bus.in_valid = 1'b0;
    drain();

    // Fill under backpressure, hold 5 cycles, release
    check_lat = 0;
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.in_ready) break;
      rand_op();
      bus.in_valid = 1'b1;
      cycle();
      n_acc++;
    end
    check("fill_count", 64'(n_acc), 64'd3);
    rand_op();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("in_ready_full", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    #1;
    check("empty_after_drain", 64'(bus.out_valid), 64'd0);
    @(negedge clk);

    // Reset with 3 operands in flight
    check_lat = 1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_lin", 64'(bus.out_lin), 64'd0);
    check("midrst_out_lin16", 64'(bus16.out_lin), 64'd0);
    q.delete();
    prev_stall = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_op(7, 'h123, 0, 1);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    drain();
    repeat (4) cycle();

    // Randomized traffic with random backpressure
    check_lat = 0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_op();
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
